// File: rtl/int_ctrl_if.sv
// int_ctrl_if -- CPU-side bus and interrupt handshake for int_ctrl.
//
// Signals:
//   address  CPU bus address (16)
//   din      CPU write data (8)
//   we_n     CPU write enable, active-low
//   dout     IF/IE read data, 8'hFF when not addressed
//   rd_hit   address matches IF or IE
//   ime_set  EI/RETI pulse, sets IME
//   ime_clr  DI pulse, clears IME (wins over ime_set)
//   int_req  interrupt request to the CPU
//   int_vec  dispatch vector, valid while int_req = 1
//   int_ack  CPU dispatch-accept pulse
//   wake     any enabled flag pending, independent of IME
//
// Modports: master = CPU core, slave = interrupt controller.
interface int_ctrl_if;
  logic [15:0] address;
  logic [7:0]  din;
  logic        we_n;
  logic [7:0]  dout;
  logic        rd_hit;
  logic        ime_set;
  logic        ime_clr;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        int_ack;
  logic        wake;

  modport master (
    output address, din, we_n, ime_set, ime_clr, int_ack,
    input  dout, rd_hit, int_req, int_vec, wake
  );

  modport slave (
    input  address, din, we_n, ime_set, ime_clr, int_ack,
    output dout, rd_hit, int_req, int_vec, wake
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl -- interrupt controller between the peripherals and the CPU core.
//
// Peripheral request levels are edge-captured into IF, masked by IE and IME,
// and the highest-priority (lowest index) pending source is presented to the
// CPU as a vector. When the CPU accepts, the serviced IF bit and IME are
// cleared and a one-cycle int_a pulse goes back to that source.
//
// Ports:
//   clk    system clock, all logic on posedge
//   Reset  asynchronous active-low reset
//   irq    per-source request level, held until its int_a
//   int_a  per-source one-cycle acknowledge pulse
//   bus    CPU bus / interrupt handshake (int_ctrl_if.slave)
module int_ctrl #(
  parameter int          NUM_SRC    = 5,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter logic [7:0]  VEC_STRIDE = 8'h08
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] irq,
  output logic [NUM_SRC-1:0] int_a,
  int_ctrl_if.slave          bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  // One-hot of the lowest set bit: bit 0 has the highest priority.
  function automatic logic [NUM_SRC-1:0] lowest_oh(input logic [NUM_SRC-1:0] p);
    lowest_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) begin
        lowest_oh    = '0;
        lowest_oh[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] vec_of(input logic [NUM_SRC-1:0] p);
    vec_of = VEC_BASE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) vec_of = VEC_BASE + VEC_STRIDE * 8'(i);
    end
  endfunction

  state_e             state_q;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic [NUM_SRC-1:0] int_a_q, int_a_d;
  logic               int_req_q;
  logic [7:0]         int_vec_q;

  logic [NUM_SRC-1:0] rise, pend_q, pend_d, ack_oh;
  logic               if_wr, ie_wr, ack_ok;
  logic [7:0]         if_rd;

  assign rise   = irq & ~irq_q;
  assign if_wr  = ~bus.we_n && (bus.address == IF_ADDR);
  assign ie_wr  = ~bus.we_n && (bus.address == IE_ADDR);
  assign pend_q = if_q & ie_q[NUM_SRC-1:0];
  assign ack_ok = (state_q == REQ) && bus.int_ack;
  assign ack_oh = lowest_oh(pend_q);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    if_d = if_q;
    if (if_wr)       if_d = bus.din[NUM_SRC-1:0];
    else if (ack_ok) if_d = if_q & ~ack_oh;
    // A rising edge always wins over a clearing write in the same cycle.
    if_d = if_d | rise;

    ie_d = ie_wr ? bus.din : ie_q;

    ime_d = ime_q;
    if (ack_ok)           ime_d = 1'b0;
    else if (bus.ime_clr) ime_d = 1'b0;
    else if (bus.ime_set) ime_d = 1'b1;

    pend_d = if_d & ie_d[NUM_SRC-1:0];

    // Acknowledge the dispatched source, and any held source whose flag the
    // CPU wipes by writing IF, so it can drop its request line.
    int_a_d = '0;
    if (ack_ok) int_a_d = ack_oh;
    if (if_wr)  int_a_d = int_a_d | (if_q & ~bus.din[NUM_SRC-1:0] & irq & ~rise);
  end

  // NOTE: all registered state uses non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      irq_q   <= '0;
      if_q    <= '0;
      ie_q    <= '0;
      ime_q   <= 1'b0;
      int_a_q <= '0;
    end else begin
      irq_q   <= irq;
      if_q    <= if_d;
      ie_q    <= ie_d;
      ime_q   <= ime_d;
      int_a_q <= int_a_d;
    end
  end

  // Request FSM. The drop/update decisions look at next-cycle IF/IE/IME so
  // int_vec always matches the flags visible while int_req is high, which
  // makes the bit cleared on int_ack the one the CPU was shown.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= VEC_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ime_q && |pend_q && ime_d && |pend_d) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
            int_vec_q <= vec_of(pend_d);
          end
        end
        REQ: begin
          if (ack_ok) begin
            state_q   <= ACK;
            int_req_q <= 1'b0;
          end else if (!ime_d || pend_d == '0) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end else begin
            int_vec_q <= vec_of(pend_d);
          end
        end
        ACK: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if_rd                = 8'hFF;
    if_rd[NUM_SRC-1:0]   = if_q;
    bus.dout             = 8'hFF;
    if (bus.address == IF_ADDR)      bus.dout = if_rd;
    else if (bus.address == IE_ADDR) bus.dout = ie_q;
  end

  assign bus.rd_hit  = (bus.address == IF_ADDR) || (bus.address == IE_ADDR);
  assign bus.int_req = int_req_q;
  assign bus.int_vec = int_vec_q;
  assign bus.wake    = |pend_q;
  assign int_a       = int_a_q;

endmodule
